// File: rtl/tx_frame_arbiter_pkg.sv
// Shared definitions for the TX frame arbiter: FSM state encoding, frame-check
// seed value and the legal requester count range.
package tx_frame_arbiter_pkg;

  // State encodings, kept as localparams so other blocks can decode state by value.
  localparam logic [1:0] ST_IDLE_ENC       = 2'd0;
  localparam logic [1:0] ST_STREAM_ENC     = 2'd1;
  localparam logic [1:0] ST_APPEND_CRC_ENC = 2'd2;

  typedef enum logic [1:0] {
    StIdle      = ST_IDLE_ENC,
    StStream    = ST_STREAM_ENC,
    StAppendCrc = ST_APPEND_CRC_ENC
  } txarb_state_e;

  // Seed of the XOR frame check; the receiver applies the same seed.
  localparam logic [7:0] CRC_INIT = 8'hFF;

  localparam int unsigned NB_REQ_MIN = 2;
  localparam int unsigned NB_REQ_MAX = 4;

  function automatic bit nb_req_legal(input int unsigned n);
    return (n >= NB_REQ_MIN) && (n <= NB_REQ_MAX);
  endfunction

endpackage

// File: rtl/tx_frame_arbiter_rr_priority_picker.sv
// Round-robin priority picker: scans the request vector upward from the pointer,
// wrapping around, and returns the first set bit as a one-hot grant and an index.
// Purely combinational.
module tx_frame_arbiter_rr_priority_picker #(
  parameter int unsigned NB_REQ = 2,
  parameter int unsigned IdxW   = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
  input  logic [NB_REQ-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NB_REQ-1:0] grant_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  // First requester at or after the pointer, with wrap.
  always_comb begin
    int unsigned cand;
    logic [IdxW-1:0] cidx;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    cidx    = '0;
    for (int unsigned off = 0; off < NB_REQ; off++) begin
      cand = (int'(ptr_i) + off) % NB_REQ;
      cidx = IdxW'(cand);
      if (!valid_o && req_i[cidx]) begin
        valid_o       = 1'b1;
        grant_o[cidx] = 1'b1;
        idx_o         = cidx;
      end
    end
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// TX frame arbiter: shares the single UART TX FIFO write port among NB_REQ frame
// producers. One requester is granted at a time (round-robin) and keeps the grant
// until its last byte is accepted, so frames are never interleaved.
// Optional feature: define TXARB_CRC_APPEND_EN to append an XOR frame-check byte
// (payload XOR 8'hFF) after every frame.
module tx_frame_arbiter
  import tx_frame_arbiter_pkg::*;
#(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_REQ  = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NB_REQ-1:0]         i_req,
  input  logic [NB_REQ-1:0]         i_valid,
  input  logic [NB_REQ-1:0]         i_last,
  input  logic [NB_REQ*NB_DATA-1:0] i_data,
  output logic [NB_REQ-1:0]         o_ready,
  output logic [NB_REQ-1:0]         o_grant,
  input  logic                      i_fifo_tx_full,
  output logic                      o_fifo_tx_write,
  output logic [NB_DATA-1:0]        o_data_to_write,
  output logic                      o_busy
);

  localparam int unsigned IdxW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

  if (!nb_req_legal(NB_REQ)) begin : g_bad_nb_req
    $error("tx_frame_arbiter: NB_REQ must be in 2..4");
  end

  txarb_state_e      state_q, state_d;
  logic [NB_REQ-1:0] grant_q, grant_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;

  logic [NB_REQ-1:0] pick_grant;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_valid;

  logic [NB_DATA-1:0] sel_data;
  logic               sel_valid;
  logic               sel_last;
  logic               accept;
  logic               stream_open;

`ifdef TXARB_CRC_APPEND_EN
  logic [NB_DATA-1:0] crc_q, crc_d;
`endif

  tx_frame_arbiter_rr_priority_picker #(
    .NB_REQ (NB_REQ),
    .IdxW   (IdxW)
  ) u_picker (
    .req_i   (i_req),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Route the granted requester's byte; grant is one-hot so an OR-mux suffices.
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < NB_REQ; k++) begin
      if (grant_q[k]) begin
        sel_data = sel_data | i_data[k*NB_DATA +: NB_DATA];
      end
    end
  end

  // Ungranted valid/last bits are masked out by the registered grant.
  assign sel_valid   = |(i_valid & grant_q);
  assign sel_last    = |(i_last & grant_q);
  assign stream_open = (state_q == StStream) && !i_fifo_tx_full;
  assign accept      = stream_open && sel_valid;

  // Ready only towards the granted producer while streaming into a non-full FIFO.
  always_comb begin
    o_ready = '0;
    if (stream_open) begin
      o_ready = grant_q;
    end
  end

  // Next-state logic, FIFO write strobe and write data.
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    ptr_d           = ptr_q;
    o_fifo_tx_write = 1'b0;
    o_data_to_write = '0;
`ifdef TXARB_CRC_APPEND_EN
    crc_d           = crc_q;
`endif
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          ptr_d   = (pick_idx == IdxW'(NB_REQ - 1)) ? '0 : pick_idx + IdxW'(1);
          state_d = StStream;
`ifdef TXARB_CRC_APPEND_EN
          crc_d   = NB_DATA'(CRC_INIT);
`endif
        end
      end
      StStream: begin
        if (accept) begin
          o_fifo_tx_write = 1'b1;
          o_data_to_write = sel_data;
`ifdef TXARB_CRC_APPEND_EN
          crc_d           = crc_q ^ sel_data;
`endif
          if (sel_last) begin
            grant_d = '0;
`ifdef TXARB_CRC_APPEND_EN
            state_d = StAppendCrc;
`else
            state_d = StIdle;
`endif
          end
        end
      end
`ifdef TXARB_CRC_APPEND_EN
      StAppendCrc: begin
        if (!i_fifo_tx_full) begin
          o_fifo_tx_write = 1'b1;
          o_data_to_write = crc_q;
          state_d         = StIdle;
        end
      end
`endif
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset abandons any frame.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
`ifdef TXARB_CRC_APPEND_EN
      crc_q   <= NB_DATA'(CRC_INIT);
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
`ifdef TXARB_CRC_APPEND_EN
      crc_q   <= crc_d;
`endif
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed self-checking bench for tx_frame_arbiter (NB_REQ=2, NB_DATA=8).
// Adapts its expectations when TXARB_CRC_APPEND_EN is defined.
module tb_tx_frame_arbiter;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [1:0]  i_req;
  logic [1:0]  i_valid;
  logic [1:0]  i_last;
  logic [15:0] i_data;
  logic [1:0]  o_ready;
  logic [1:0]  o_grant;
  logic        i_fifo_tx_full;
  logic        o_fifo_tx_write;
  logic [7:0]  o_data_to_write;
  logic        o_busy;

  int total = 0;
  int bad   = 0;
  int ovf   = 0;

  logic [7:0] wq[$];   // bytes seen on the FIFO write port
  logic [1:0] gq[$];   // grant at the time of each write
  logic [8:0] fq0[$];  // {last, byte} frames queued for requester 0
  logic [8:0] fq1[$];  // {last, byte} frames queued for requester 1

  tx_frame_arbiter #(
    .NB_DATA (8),
    .NB_REQ  (2)
  ) dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_req           (i_req),
    .i_valid         (i_valid),
    .i_last          (i_last),
    .i_data          (i_data),
    .o_ready         (o_ready),
    .o_grant         (o_grant),
    .i_fifo_tx_full  (i_fifo_tx_full),
    .o_fifo_tx_write (o_fifo_tx_write),
    .o_data_to_write (o_data_to_write),
    .o_busy          (o_busy)
  );

  initial forever #5 clk = ~clk;

  // FIFO-side monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_fifo_tx_write === 1'b1) begin
      wq.push_back(o_data_to_write);
      gq.push_back(o_grant);
      if (i_fifo_tx_full === 1'b1) ovf++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req = '0; i_valid = '0; i_last = '0; i_data = '0; i_fifo_tx_full = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_reset = 1'b0;
    step();
    step();
    i_reset = 1'b1;
    wq.delete();
    gq.delete();
  endtask

  // Drives queued frames for both requesters until all are sent and the DUT is idle.
  task automatic run_engine(input int budget, input int full_from, input int full_len);
    int  c = 0;
    bit  done = 0;
    bit  acc0, acc1;
    while (!done && c < budget) begin
      i_req   = {fq1.size() > 0, fq0.size() > 0};
      i_valid = i_req;
      i_last  = {(fq1.size() > 0) ? fq1[0][8] : 1'b0, (fq0.size() > 0) ? fq0[0][8] : 1'b0};
      i_data  = {(fq1.size() > 0) ? fq1[0][7:0] : 8'h00, (fq0.size() > 0) ? fq0[0][7:0] : 8'h00};
      i_fifo_tx_full = (c >= full_from) && (c < full_from + full_len);
      #1;
      if (i_fifo_tx_full) begin
        total++;
        if (o_ready !== 2'b00 || o_fifo_tx_write !== 1'b0) begin
          bad++;
          $display("FAIL full_stall c=%0d: ready=%b write=%b, required ready=00 write=0",
                   c, o_ready, o_fifo_tx_write);
        end
      end
      acc0 = i_valid[0] & o_ready[0];
      acc1 = i_valid[1] & o_ready[1];
      step();
      if (acc0) void'(fq0.pop_front());
      if (acc1) void'(fq1.pop_front());
      c++;
      done = (fq0.size() == 0) && (fq1.size() == 0) && (o_busy === 1'b0);
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL engine_timeout: done=%0d after %0d cycles, required done=1", done, c);
    end
    fq0.delete();
    fq1.delete();
    clear_inputs();
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    i_req = 2'b11; i_valid = 2'b11; i_last = 2'b11; i_data = 16'hFFFF;
    i_fifo_tx_full = 1'b0;
    step();
    step();
    total++;
    if (o_grant !== 2'b00 || o_ready !== 2'b00 || o_fifo_tx_write !== 1'b0 ||
        o_data_to_write !== 8'h00 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: grant=%b ready=%b write=%b data=%h busy=%b, required all 0",
               o_grant, o_ready, o_fifo_tx_write, o_data_to_write, o_busy);
    end
    do_reset();
  endtask

  task automatic test_single_frame();
    logic [7:0] exp_d[$];
    do_reset();
    i_req = 2'b01; i_valid = 2'b01; i_data = 16'h0012; i_last = 2'b00;
    #1;
    total++;
    if (o_grant !== 2'b00 || o_ready !== 2'b00 || o_fifo_tx_write !== 1'b0) begin
      bad++;
      $display("FAIL t1_idle: grant=%b ready=%b write=%b, required 00 00 0",
               o_grant, o_ready, o_fifo_tx_write);
    end
    step();
    total++;
    if (o_grant !== 2'b01 || o_ready !== 2'b01 || o_fifo_tx_write !== 1'b1 ||
        o_data_to_write !== 8'h12 || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL t1_first: grant=%b ready=%b write=%b data=%h busy=%b, required 01 01 1 12 1",
               o_grant, o_ready, o_fifo_tx_write, o_data_to_write, o_busy);
    end
    step();
    i_data = 16'h0034; i_last = 2'b01;
    #1;
    total++;
    if (o_fifo_tx_write !== 1'b1 || o_data_to_write !== 8'h34 || o_grant !== 2'b01) begin
      bad++;
      $display("FAIL t1_last: write=%b data=%h grant=%b, required 1 34 01",
               o_fifo_tx_write, o_data_to_write, o_grant);
    end
    step();
    clear_inputs();
    #1;
`ifdef TXARB_CRC_APPEND_EN
    total++;
    if (o_fifo_tx_write !== 1'b1 || o_data_to_write !== 8'hD9 || o_grant !== 2'b00 ||
        o_ready !== 2'b00) begin
      bad++;
      $display("FAIL t1_crc: write=%b data=%h grant=%b ready=%b, required 1 d9 00 00",
               o_fifo_tx_write, o_data_to_write, o_grant, o_ready);
    end
    step();
`endif
    total++;
    if (o_grant !== 2'b00 || o_busy !== 1'b0 || o_fifo_tx_write !== 1'b0) begin
      bad++;
      $display("FAIL t1_end: grant=%b busy=%b write=%b, required 00 0 0",
               o_grant, o_busy, o_fifo_tx_write);
    end
    exp_d = '{8'h12, 8'h34};
`ifdef TXARB_CRC_APPEND_EN
    exp_d.push_back(8'hD9);
`endif
    total++;
    if (wq.size() != exp_d.size()) begin
      bad++;
      $display("FAIL t1_count: writes=%0d, required %0d", wq.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < wq.size(); i++) begin
      total++;
      if (wq[i] !== exp_d[i]) begin
        bad++;
        $display("FAIL t1_byte%0d: got %h, required %h", i, wq[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d[$];
    logic [1:0] exp_g[$];
    do_reset();
    fq0 = '{9'h0A1, 9'h1B2, 9'h0C3, 9'h1D4, 9'h0E5, 9'h1F6};
    fq1 = '{9'h017, 9'h128, 9'h039, 9'h14A, 9'h05B, 9'h16C};
    run_engine(200, -1, 0);
`ifdef TXARB_CRC_APPEND_EN
    exp_d = '{8'hA1, 8'hB2, 8'hEC, 8'h17, 8'h28, 8'hC0, 8'hC3, 8'hD4, 8'hE8,
              8'h39, 8'h4A, 8'h8C, 8'hE5, 8'hF6, 8'hEC, 8'h5B, 8'h6C, 8'hC8};
    exp_g = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00,
              2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
`else
    exp_d = '{8'hA1, 8'hB2, 8'h17, 8'h28, 8'hC3, 8'hD4,
              8'h39, 8'h4A, 8'hE5, 8'hF6, 8'h5B, 8'h6C};
    exp_g = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01,
              2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
`endif
    total++;
    if (wq.size() != exp_d.size()) begin
      bad++;
      $display("FAIL t2_count: writes=%0d, required %0d", wq.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < wq.size(); i++) begin
      total++;
      if (wq[i] !== exp_d[i] || gq[i] !== exp_g[i]) begin
        bad++;
        $display("FAIL t2_byte%0d: got %h grant %b, required %h grant %b",
                 i, wq[i], gq[i], exp_d[i], exp_g[i]);
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] exp_d[$];
    do_reset();
    fq0 = '{9'h010, 9'h020, 9'h030, 9'h140};
    run_engine(100, 2, 5);
    exp_d = '{8'h10, 8'h20, 8'h30, 8'h40};
`ifdef TXARB_CRC_APPEND_EN
    exp_d.push_back(8'hBF);
`endif
    total++;
    if (wq.size() != exp_d.size()) begin
      bad++;
      $display("FAIL t3_count: writes=%0d, required %0d", wq.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < wq.size(); i++) begin
      total++;
      if (wq[i] !== exp_d[i]) begin
        bad++;
        $display("FAIL t3_byte%0d: got %h, required %h", i, wq[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_single_byte_crc_stall();
    logic [7:0] exp_d[$];
    do_reset();
    fq0 = '{9'h1A5};
    run_engine(100, 2, 3);
    exp_d = '{8'hA5};
`ifdef TXARB_CRC_APPEND_EN
    exp_d.push_back(8'h5A);
`endif
    total++;
    if (wq.size() != exp_d.size()) begin
      bad++;
      $display("FAIL t4_count: writes=%0d, required %0d", wq.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < wq.size(); i++) begin
      total++;
      if (wq[i] !== exp_d[i]) begin
        bad++;
        $display("FAIL t4_byte%0d: got %h, required %h", i, wq[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    do_reset();
    i_req = 2'b01; i_valid = 2'b01; i_data = 16'h0061; i_last = 2'b00;
    step();
    step();
    i_data = 16'h0062;
    #1;
    total++;
    if (o_fifo_tx_write !== 1'b1 || o_data_to_write !== 8'h62) begin
      bad++;
      $display("FAIL t5_second: write=%b data=%h, required 1 62",
               o_fifo_tx_write, o_data_to_write);
    end
    step();
    i_data = 16'h0063; i_valid = 2'b00; i_reset = 1'b0;
    step();
    total++;
    if (o_grant !== 2'b00 || o_ready !== 2'b00 || o_fifo_tx_write !== 1'b0 ||
        o_data_to_write !== 8'h00 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL t5_reset: grant=%b ready=%b write=%b data=%h busy=%b, required all 0",
               o_grant, o_ready, o_fifo_tx_write, o_data_to_write, o_busy);
    end
    i_reset = 1'b1; i_req = 2'b11;
    step();
    total++;
    if (o_grant !== 2'b01) begin
      bad++;
      $display("FAIL t5_regrant: grant=%b, required 01", o_grant);
    end
    total++;
    if (wq.size() != 2) begin
      bad++;
      $display("FAIL t5_count: writes=%0d, required 2", wq.size());
    end
    for (int i = 0; i < 2 && i < wq.size(); i++) begin
      total++;
      if (wq[i] !== 8'(8'h61 + i)) begin
        bad++;
        $display("FAIL t5_byte%0d: got %h, required %h", i, wq[i], 8'(8'h61 + i));
      end
    end
    clear_inputs();
  endtask

  task automatic test_ignore_and_hold();
    logic [7:0] exp_d[$];
    do_reset();
    i_req = 2'b01; i_valid = 2'b11; i_data = 16'hEE71; i_last = 2'b10;
    step();
    total++;
    if (o_grant !== 2'b01 || o_ready !== 2'b01 || o_data_to_write !== 8'h71) begin
      bad++;
      $display("FAIL t6_first: grant=%b ready=%b data=%h, required 01 01 71",
               o_grant, o_ready, o_data_to_write);
    end
    step();
    i_req = 2'b10; i_data = 16'hEE72;
    #1;
    total++;
    if (o_grant !== 2'b01 || o_ready !== 2'b01 || o_data_to_write !== 8'h72) begin
      bad++;
      $display("FAIL t6_drop_req: grant=%b ready=%b data=%h, required 01 01 72",
               o_grant, o_ready, o_data_to_write);
    end
    step();
    i_data = 16'hEE73; i_last = 2'b11;
    #1;
    total++;
    if (o_grant !== 2'b01 || o_fifo_tx_write !== 1'b1 || o_data_to_write !== 8'h73) begin
      bad++;
      $display("FAIL t6_last: grant=%b write=%b data=%h, required 01 1 73",
               o_grant, o_fifo_tx_write, o_data_to_write);
    end
    step();
    i_valid = 2'b00; i_last = 2'b00;
    #1;
    total++;
    if (o_grant !== 2'b00) begin
      bad++;
      $display("FAIL t6_release: grant=%b, required 00", o_grant);
    end
`ifdef TXARB_CRC_APPEND_EN
    total++;
    if (o_fifo_tx_write !== 1'b1 || o_data_to_write !== 8'h8F) begin
      bad++;
      $display("FAIL t6_crc: write=%b data=%h, required 1 8f", o_fifo_tx_write, o_data_to_write);
    end
    step();
`endif
    step();
    total++;
    if (o_grant !== 2'b10) begin
      bad++;
      $display("FAIL t6_next_grant: grant=%b, required 10", o_grant);
    end
    exp_d = '{8'h71, 8'h72, 8'h73};
`ifdef TXARB_CRC_APPEND_EN
    exp_d.push_back(8'h8F);
`endif
    total++;
    if (wq.size() != exp_d.size()) begin
      bad++;
      $display("FAIL t6_count: writes=%0d, required %0d", wq.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < wq.size(); i++) begin
      total++;
      if (wq[i] !== exp_d[i]) begin
        bad++;
        $display("FAIL t6_byte%0d: got %h, required %h", i, wq[i], exp_d[i]);
      end
    end
    clear_inputs();
  endtask

  initial begin
    i_reset = 1'b0;
    clear_inputs();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_fifo_full();
    test_single_byte_crc_stall();
    test_mid_frame_reset();
    test_ignore_and_hold();
    total++;
    if (ovf != 0) begin
      bad++;
      $display("FAIL overflow: writes while full=%0d, required 0", ovf);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
